// File: rtl/sr_trace_buffer_if.sv
// Capture, trigger and readout bundle between the core-side host and sr_trace_buffer.
// The master drives retirement/trigger/read-index signals; the slave returns status and read data.
interface sr_trace_buffer_if #(
  parameter int AW = 4
);
  logic          arm;
  logic          valid;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic [31:0]   a0;
  logic [31:0]   trigPc;
  logic          trigPcEn;
  logic [AW-1:0] rdIdx;
  logic [31:0]   rdPc;
  logic [31:0]   rdInstr;
  logic [31:0]   rdA0;
  logic [AW:0]   count;
  logic [31:0]   cycle;
  logic [1:0]    state;
  logic [1:0]    cause;
  logic          done;

  modport master (
    output arm, valid, pc, instr, a0, trigPc, trigPcEn, rdIdx,
    input  rdPc, rdInstr, rdA0, count, cycle, state, cause, done
  );

  modport slave (
    input  arm, valid, pc, instr, a0, trigPc, trigPcEn, rdIdx,
    output rdPc, rdInstr, rdA0, count, cycle, state, cause, done
  );
endinterface

// File: rtl/sr_trace_buffer.sv
// Circular trace of retired {pc, instr, a0}, frozen by PC match, halt loop or timeout.
// Writes land on the valid edge; indexed reads return registered data one cycle later.
module sr_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int HALT_N    = 4,
  parameter int TIMEOUT   = 450,
  parameter int AW        = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rst,
  sr_trace_buffer_if.slave  bus
);
  localparam int HW = $clog2(HALT_N);

  typedef enum logic [1:0] {IDLE, ARMED, TRIGGERED, DONE} state_t;

  state_t        stateQ, stateNext;
  logic [AW-1:0] wp;
  logic [AW:0]   countQ;
  logic [31:0]   cycleQ;
  logic [1:0]    causeQ, causeNext;
  logic [HW-1:0] haltCnt;
  logic [AW-1:0] postCnt;
  logic [31:0]   lastPc;
  logic [31:0]   rdPcQ, rdInstrQ, rdA0Q;
  logic          wrEn, pcHit, samePc, haltHit, toHit;
  logic [AW-1:0] rdAddr;

  logic [31:0] pcMem    [DEPTH];
  logic [31:0] instrMem [DEPTH];
  logic [31:0] a0Mem    [DEPTH];

  // An empty buffer has no previous pc, so the first entry never extends a halt run.
  assign samePc  = (countQ != '0) && (bus.pc == lastPc);
  assign pcHit   = bus.valid && bus.trigPcEn && (bus.pc == bus.trigPc);
  assign haltHit = bus.valid && samePc && (haltCnt == HW'(HALT_N - 2));
  assign toHit   = (cycleQ == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateQ <= IDLE;
    else     stateQ <= stateNext;
  end

  always_comb begin
    stateNext = stateQ;
    causeNext = 2'd0;
    wrEn      = 1'b0;
    if (bus.arm) begin
      stateNext = ARMED;
    end else begin
      case (stateQ)
        ARMED: begin
          wrEn = bus.valid;
          if (pcHit)        causeNext = 2'd1;
          else if (haltHit) causeNext = 2'd2;
          else if (toHit)   causeNext = 2'd3;
          if (causeNext != 2'd0) stateNext = (POST_TRIG == 0) ? DONE : TRIGGERED;
        end
        TRIGGERED: begin
          wrEn = bus.valid;
          if (bus.valid && postCnt == AW'(1)) stateNext = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp      <= '0;
      countQ  <= '0;
      cycleQ  <= '0;
      causeQ  <= '0;
      haltCnt <= '0;
      postCnt <= '0;
      lastPc  <= '0;
    end else if (bus.arm) begin
      wp      <= '0;
      countQ  <= '0;
      cycleQ  <= '0;
      causeQ  <= '0;
      haltCnt <= '0;
      postCnt <= '0;
      lastPc  <= '0;
    end else begin
      if ((stateQ == ARMED || stateQ == TRIGGERED) && cycleQ != '1)
        cycleQ <= cycleQ + 32'd1;
      if (wrEn) begin
        wp     <= wp + AW'(1);
        lastPc <= bus.pc;
        if (countQ != (AW+1)'(DEPTH)) countQ <= countQ + (AW+1)'(1);
        if (!samePc)                          haltCnt <= '0;
        else if (haltCnt != HW'(HALT_N - 1)) haltCnt <= haltCnt + HW'(1);
        if (stateQ == TRIGGERED) postCnt <= postCnt - AW'(1);
      end
      if (causeNext != 2'd0) begin
        causeQ  <= causeNext;
        postCnt <= AW'(POST_TRIG);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      pcMem[wp]    <= bus.pc;
      instrMem[wp] <= bus.instr;
      a0Mem[wp]    <= bus.a0;
    end
  end

  // Index 0 is the oldest entry; once full, count's low bits are zero and oldest == wp.
  assign rdAddr = wp - countQ[AW-1:0] + bus.rdIdx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPcQ    <= '0;
      rdInstrQ <= '0;
      rdA0Q    <= '0;
    end else if ({1'b0, bus.rdIdx} < countQ) begin
      rdPcQ    <= pcMem[rdAddr];
      rdInstrQ <= instrMem[rdAddr];
      rdA0Q    <= a0Mem[rdAddr];
    end else begin
      rdPcQ    <= '0;
      rdInstrQ <= '0;
      rdA0Q    <= '0;
    end
  end

  assign bus.rdPc    = rdPcQ;
  assign bus.rdInstr = rdInstrQ;
  assign bus.rdA0    = rdA0Q;
  assign bus.count   = countQ;
  assign bus.cycle   = cycleQ;
  assign bus.state   = stateQ;
  assign bus.cause   = causeQ;
  assign bus.done    = (stateQ == DONE);
endmodule

// File: tb/tb_sr_trace_buffer.sv
// Directed bench: dut1 (POST_TRIG=8) covers capture/triggers/reset, dut0 (POST_TRIG=0) covers timeout.
module tb_sr_trace_buffer;
  logic clk = 1'b0;
  logic rst;
  int   nChk  = 0;
  int   nPass = 0;

  always #5 clk = ~clk;

  sr_trace_buffer_if #(.AW(4)) b0 ();
  sr_trace_buffer_if #(.AW(4)) b1 ();

  sr_trace_buffer #(.DEPTH(16), .POST_TRIG(0), .HALT_N(4), .TIMEOUT(450)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  sr_trace_buffer #(.DEPTH(16), .POST_TRIG(8), .HALT_N(4), .TIMEOUT(450)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  function automatic logic [31:0] expInstr(input logic [31:0] p);
    return p ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] expA0(input logic [31:0] p);
    return p + 32'h0000_1000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm1();
    b1.arm = 1'b1;
    tick();
    b1.arm = 1'b0;
  endtask

  task automatic retire(input logic [31:0] p);
    b1.valid = 1'b1;
    b1.pc    = p;
    b1.instr = expInstr(p);
    b1.a0    = expA0(p);
    tick();
    b1.valid = 1'b0;
  endtask

  task automatic read1(input logic [3:0] idx);
    b1.rdIdx = idx;
    tick();
  endtask

  task automatic test_reset();
    #2;
    nChk++; if (b1.state !== 2'd0) $display("FAIL rst_state: got %0d want 0", b1.state); else nPass++;
    nChk++; if (b1.count !== 5'd0) $display("FAIL rst_count: got %0d want 0", b1.count); else nPass++;
    nChk++; if (b1.cycle !== 32'd0) $display("FAIL rst_cycle: got %0d want 0", b1.cycle); else nPass++;
    nChk++; if (b1.cause !== 2'd0 || b1.done !== 1'b0) $display("FAIL rst_cause_done: got %0d/%0d want 0/0", b1.cause, b1.done); else nPass++;
    nChk++; if (b1.rdPc !== 32'd0) $display("FAIL rst_rdPc: got %h want 0", b1.rdPc); else nPass++;
    nChk++; if (b0.state !== 2'd0) $display("FAIL rst_state0: got %0d want 0", b0.state); else nPass++;
    tick();
    rst = 1'b0;
    tick();
    nChk++; if (b1.state !== 2'd0 || b1.cycle !== 32'd0) $display("FAIL idle_hold: got state %0d cycle %0d want 0 0", b1.state, b1.cycle); else nPass++;
  endtask

  task automatic test_linear();
    arm1();
    for (int i = 0; i < 10; i++) retire(32'(4 * i));
    nChk++; if (b1.count !== 5'd10) $display("FAIL lin_count: got %0d want 10", b1.count); else nPass++;
    nChk++; if (b1.cycle !== 32'd10) $display("FAIL lin_cycle: got %0d want 10", b1.cycle); else nPass++;
    nChk++; if (b1.state !== 2'd1) $display("FAIL lin_state: got %0d want 1", b1.state); else nPass++;
    read1(4'd0);
    nChk++; if (b1.rdPc !== 32'h00) $display("FAIL lin_rd0: got %h want 0", b1.rdPc); else nPass++;
    read1(4'd9);
    nChk++; if (b1.rdPc !== 32'h24 || b1.rdInstr !== expInstr(32'h24) || b1.rdA0 !== expA0(32'h24))
      $display("FAIL lin_rd9: got %h/%h/%h want %h/%h/%h", b1.rdPc, b1.rdInstr, b1.rdA0, 32'h24, expInstr(32'h24), expA0(32'h24));
    else nPass++;
    read1(4'd10);
    nChk++; if (b1.rdPc !== 32'd0 || b1.rdInstr !== 32'd0 || b1.rdA0 !== 32'd0)
      $display("FAIL lin_rd10: got %h/%h/%h want 0/0/0", b1.rdPc, b1.rdInstr, b1.rdA0);
    else nPass++;
  endtask

  task automatic test_wrap_pc();
    arm1();
    b1.trigPc   = 32'h50;
    b1.trigPcEn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      retire(32'(4 * i));
      if (i == 19) begin
        nChk++; if (b1.state !== 2'd1) $display("FAIL wrap_pre: got %0d want 1", b1.state); else nPass++;
      end
      if (i == 20) begin
        nChk++; if (b1.state !== 2'd2 || b1.cause !== 2'd1) $display("FAIL wrap_trig: got %0d/%0d want 2/1", b1.state, b1.cause); else nPass++;
      end
      if (i == 27) begin
        nChk++; if (b1.state !== 2'd2) $display("FAIL wrap_post: got %0d want 2", b1.state); else nPass++;
      end
      if (i == 28) begin
        nChk++; if (b1.state !== 2'd3 || b1.done !== 1'b1) $display("FAIL wrap_done: got %0d/%0d want 3/1", b1.state, b1.done); else nPass++;
      end
    end
    b1.trigPcEn = 1'b0;
    nChk++; if (b1.count !== 5'd16) $display("FAIL wrap_count: got %0d want 16", b1.count); else nPass++;
    nChk++; if (b1.cause !== 2'd1) $display("FAIL wrap_cause: got %0d want 1", b1.cause); else nPass++;
    read1(4'd0);
    nChk++; if (b1.rdPc !== 32'h34 || b1.rdA0 !== expA0(32'h34)) $display("FAIL wrap_rd0: got %h/%h want %h/%h", b1.rdPc, b1.rdA0, 32'h34, expA0(32'h34)); else nPass++;
    read1(4'd15);
    nChk++; if (b1.rdPc !== 32'h70) $display("FAIL wrap_rd15: got %h want 70", b1.rdPc); else nPass++;
    retire(32'h200);
    retire(32'h204);
    read1(4'd0);
    nChk++; if (b1.count !== 5'd16 || b1.rdPc !== 32'h34) $display("FAIL done_hold: got count %0d pc %h want 16 34", b1.count, b1.rdPc); else nPass++;
  endtask

  task automatic test_halt();
    arm1();
    retire(32'h10);
    retire(32'h14);
    for (int i = 0; i < 3; i++) retire(32'h18);
    nChk++; if (b1.state !== 2'd1) $display("FAIL halt_pre: got %0d want 1", b1.state); else nPass++;
    retire(32'h18);
    nChk++; if (b1.state !== 2'd2 || b1.cause !== 2'd2) $display("FAIL halt_trig: got %0d/%0d want 2/2", b1.state, b1.cause); else nPass++;
    nChk++; if (b1.count !== 5'd6) $display("FAIL halt_count: got %0d want 6", b1.count); else nPass++;
  endtask

  task automatic test_timeout();
    b0.arm = 1'b1;
    tick();
    b0.arm = 1'b0;
    for (int k = 1; k < 450; k++) tick();
    nChk++; if (b0.state !== 2'd1 || b0.cycle !== 32'd449) $display("FAIL to_pre: got %0d/%0d want 1/449", b0.state, b0.cycle); else nPass++;
    tick();
    nChk++; if (b0.state !== 2'd3 || b0.done !== 1'b1) $display("FAIL to_done: got %0d/%0d want 3/1", b0.state, b0.done); else nPass++;
    nChk++; if (b0.cause !== 2'd3 || b0.count !== 5'd0) $display("FAIL to_cause: got %0d/%0d want 3/0", b0.cause, b0.count); else nPass++;
    tick();
    tick();
    nChk++; if (b0.cycle !== 32'd450) $display("FAIL to_cycle_hold: got %0d want 450", b0.cycle); else nPass++;
  endtask

  task automatic test_simultaneous();
    arm1();
    b1.trigPc = 32'h40;
    for (int i = 0; i < 3; i++) retire(32'h40);
    nChk++; if (b1.state !== 2'd1) $display("FAIL sim_pre: got %0d want 1", b1.state); else nPass++;
    b1.trigPcEn = 1'b1;
    retire(32'h40);
    b1.trigPcEn = 1'b0;
    nChk++; if (b1.state !== 2'd2 || b1.cause !== 2'd1) $display("FAIL sim_prio: got %0d/%0d want 2/1", b1.state, b1.cause); else nPass++;
    b1.arm   = 1'b1;
    b1.valid = 1'b1;
    b1.pc    = 32'h99;
    tick();
    b1.arm   = 1'b0;
    b1.valid = 1'b0;
    nChk++; if (b1.count !== 5'd0 || b1.state !== 2'd1) $display("FAIL arm_valid: got count %0d state %0d want 0 1", b1.count, b1.state); else nPass++;
    nChk++; if (b1.cycle !== 32'd0 || b1.cause !== 2'd0) $display("FAIL arm_clear: got cycle %0d cause %0d want 0 0", b1.cycle, b1.cause); else nPass++;
  endtask

  task automatic test_reset_mid();
    arm1();
    b1.trigPc   = 32'h8;
    b1.trigPcEn = 1'b1;
    retire(32'h0);
    retire(32'h4);
    retire(32'h8);
    b1.trigPcEn = 1'b0;
    nChk++; if (b1.state !== 2'd2) $display("FAIL mid_trig: got %0d want 2", b1.state); else nPass++;
    read1(4'd1);
    nChk++; if (b1.rdPc !== 32'h4) $display("FAIL mid_rd1: got %h want 4", b1.rdPc); else nPass++;
    #2 rst = 1'b1;
    #1;
    nChk++; if (b1.state !== 2'd0 || b1.done !== 1'b0 || b1.cause !== 2'd0)
      $display("FAIL mid_rst_state: got %0d/%0d/%0d want 0/0/0", b1.state, b1.done, b1.cause);
    else nPass++;
    nChk++; if (b1.count !== 5'd0 || b1.cycle !== 32'd0 || b1.rdPc !== 32'd0)
      $display("FAIL mid_rst_data: got %0d/%0d/%h want 0/0/0", b1.count, b1.cycle, b1.rdPc);
    else nPass++;
    #2 rst = 1'b0;
    tick();
    arm1();
    retire(32'h100);
    retire(32'h104);
    nChk++; if (b1.count !== 5'd2 || b1.state !== 2'd1 || b1.cause !== 2'd0)
      $display("FAIL rearm: got %0d/%0d/%0d want 2/1/0", b1.count, b1.state, b1.cause);
    else nPass++;
    read1(4'd0);
    nChk++; if (b1.rdPc !== 32'h100) $display("FAIL rearm_rd0: got %h want 100", b1.rdPc); else nPass++;
    read1(4'd1);
    nChk++; if (b1.rdA0 !== expA0(32'h104)) $display("FAIL rearm_rd1: got %h want %h", b1.rdA0, expA0(32'h104)); else nPass++;
  endtask

  initial begin
    rst = 1'b1;
    b0.arm = 1'b0; b0.valid = 1'b0; b0.pc = '0; b0.instr = '0; b0.a0 = '0;
    b0.trigPc = '0; b0.trigPcEn = 1'b0; b0.rdIdx = '0;
    b1.arm = 1'b0; b1.valid = 1'b0; b1.pc = '0; b1.instr = '0; b1.a0 = '0;
    b1.trigPc = '0; b1.trigPcEn = 1'b0; b1.rdIdx = '0;
    test_reset();
    test_linear();
    test_wrap_pc();
    test_halt();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
